// File: rtl/regfile_alu_pkg.sv
// Shared opcode encodings, flag bit positions and opcode helpers for regfile_alu_pipe.
// Pure definitions, no latency; no flow control.
// Imported by the ALU core, the pipeline top and the bench.
package regfile_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_LSH  = 4'd7;
    localparam logic [3:0] OP_RSH  = 4'd8;
    localparam logic [3:0] OP_ARSH = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;

    localparam int FLAG_W = 5;
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // CMP and the unused codes never touch the register file.
    function automatic logic op_writes(input logic [3:0] op);
        return (op <= OP_MOV) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/regfile_alu_pipe_if.sv
// Issue and result bundle for regfile_alu_pipe; master issues ops, slave executes.
// No latency of its own; In_Valid/In_Ready on issue, Out_Valid is an unthrottled pulse.
// Widths follow the DATA_W / NUM_REGS parameters of the instance.
interface regfile_alu_pipe_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
);
    localparam int REG_AW = $clog2(NUM_REGS);

    logic              In_Valid;
    logic              In_Ready;
    logic [3:0]        OpCode;
    logic [REG_AW-1:0] RdestRegLoc;
    logic [REG_AW-1:0] RsrcRegLoc;
    logic [DATA_W-1:0] Imm;
    logic              Imm_s;
    logic              Wb_En;
    logic              Out_Valid;
    logic [DATA_W-1:0] AluOutput;
    logic [DATA_W-1:0] RdestOut;
    logic [DATA_W-1:0] AluSrcIn;
    logic [4:0]        Flags;

    modport master (
        output In_Valid, OpCode, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, Wb_En,
        input  In_Ready, Out_Valid, AluOutput, RdestOut, AluSrcIn, Flags
    );

    modport slave (
        input  In_Valid, OpCode, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, Wb_En,
        output In_Ready, Out_Valid, AluOutput, RdestOut, AluSrcIn, Flags
    );

endinterface

// File: rtl/regfile_alu_pipe_alu_core.sv
// Combinational ALU: result plus carry/borrow, unsigned-less, overflow, equal, signed-less.
// Zero latency; no flow control.
module alu_core
    import regfile_alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              c_o,
    output logic              l_o,
    output logic              f_o,
    output logic              z_o,
    output logic              n_o
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [SH_W-1:0]   sh;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        sh   = b[SH_W-1:0];

        // Top bit of the widened difference is the borrow.
        c_o = (op == OP_SUB) ? diff[DATA_W] : sum[DATA_W];
        f_o = (op == OP_SUB) ? ((a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]))
                             : ((a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]));
        l_o = (a < b);
        z_o = (a == b);
        n_o = ($signed(a) < $signed(b));

        res = '0;
        case (op)
            OP_ADD:  res = sum[DATA_W-1:0];
            OP_SUB:  res = diff[DATA_W-1:0];
            OP_CMP:  res = diff[DATA_W-1:0];
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~b;
            OP_LSH:  res = a << sh;
            OP_RSH:  res = a >> sh;
            OP_ARSH: res = $signed(a) >>> sh;
            OP_MOV:  res = b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Two-stage register file + ALU: operand read/issue, then EX with writeback and flag update.
// Latency 2 edges, 1 op/cycle; RAW hazard stalls In_Ready one cycle unless REGFILE_ALU_FWD_EN.
// REGFILE_ALU_FWD_EN forwards the EX result into the operand read instead of stalling.
module regfile_alu_pipe
    import regfile_alu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    regfile_alu_pipe_if.slave   bus
);
    localparam int REG_AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              ex_vld_q, ex_vld_d;
    logic              ex_wr_q, ex_wr_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] rdest_out_q, rdest_out_d;
    logic [DATA_W-1:0] src_out_q, src_out_d;
    logic [4:0]        flags_q, flags_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_l, alu_f, alu_z, alu_n;
    logic              rd_hit, rs_hit, stall, accept;
    logic [DATA_W-1:0] rd_val, rs_val, src_val;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op  (ex_op_q),
        .a   (ex_a_q),
        .b   (ex_b_q),
        .res (alu_res),
        .c_o (alu_c),
        .l_o (alu_l),
        .f_o (alu_f),
        .z_o (alu_z),
        .n_o (alu_n)
    );

    always_comb begin
        rd_hit = ex_vld_q && ex_wr_q && (bus.RdestRegLoc == ex_dst_q);
        rs_hit = ex_vld_q && ex_wr_q && !bus.Imm_s && (bus.RsrcRegLoc == ex_dst_q);
        rd_val = regs_q[bus.RdestRegLoc];
        rs_val = regs_q[bus.RsrcRegLoc];
`ifdef REGFILE_ALU_FWD_EN
        stall = 1'b0;
        if (rd_hit) rd_val = alu_res;
        if (rs_hit) rs_val = alu_res;
`else
        // One bubble lets the EX op retire, so the retry reads the written value.
        stall = bus.In_Valid && (rd_hit || rs_hit);
`endif
        src_val = bus.Imm_s ? bus.Imm : rs_val;
    end

    assign bus.In_Ready = Rst && !stall;
    assign accept       = bus.In_Valid && bus.In_Ready;

    always_comb begin
        ex_vld_d = accept;
        ex_wr_d  = ex_wr_q;
        ex_op_d  = ex_op_q;
        ex_dst_d = ex_dst_q;
        ex_a_d   = ex_a_q;
        ex_b_d   = ex_b_q;
        if (accept) begin
            ex_wr_d  = bus.Wb_En && op_writes(bus.OpCode);
            ex_op_d  = bus.OpCode;
            ex_dst_d = bus.RdestRegLoc;
            ex_a_d   = rd_val;
            ex_b_d   = src_val;
        end
    end

    always_comb begin
        regs_d      = regs_q;
        out_vld_d   = ex_vld_q;
        alu_out_d   = alu_out_q;
        rdest_out_d = rdest_out_q;
        src_out_d   = src_out_q;
        flags_d     = flags_q;
        if (ex_vld_q) begin
            if (ex_wr_q) regs_d[ex_dst_q] = alu_res;
            alu_out_d   = alu_res;
            rdest_out_d = ex_a_q;
            src_out_d   = ex_b_q;
            case (ex_op_q)
                OP_ADD, OP_SUB: begin
                    flags_d[FLAG_C] = alu_c;
                    flags_d[FLAG_F] = alu_f;
                end
                OP_CMP: begin
                    flags_d[FLAG_L] = alu_l;
                    flags_d[FLAG_Z] = alu_z;
                    flags_d[FLAG_N] = alu_n;
                end
                default: flags_d = flags_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            ex_vld_q    <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_op_q     <= '0;
            ex_dst_q    <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            out_vld_q   <= 1'b0;
            alu_out_q   <= '0;
            rdest_out_q <= '0;
            src_out_q   <= '0;
            flags_q     <= '0;
        end else begin
            regs_q      <= regs_d;
            ex_vld_q    <= ex_vld_d;
            ex_wr_q     <= ex_wr_d;
            ex_op_q     <= ex_op_d;
            ex_dst_q    <= ex_dst_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            out_vld_q   <= out_vld_d;
            alu_out_q   <= alu_out_d;
            rdest_out_q <= rdest_out_d;
            src_out_q   <= src_out_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.Out_Valid = out_vld_q;
    assign bus.AluOutput = alu_out_q;
    assign bus.RdestOut  = rdest_out_q;
    assign bus.AluSrcIn  = src_out_q;
    assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Bench for regfile_alu_pipe: directed scenarios then random ops against an in-order ISA model.
// Expected results are queued at issue and matched against each Out_Valid pulse.
module tb_regfile_alu_pipe;
    import regfile_alu_pkg::*;

    localparam int DW = 16;
    localparam int NR = 16;
`ifdef REGFILE_ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    regfile_alu_pipe_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

    regfile_alu_pipe #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        int          op;
        logic [15:0] res;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_regs [NR];
    logic [4:0]  m_flags;
    int          last_wr = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Architectural model: each op sees the effect of every earlier op, in order.
    task automatic model_step(input int op, input int d, input int s,
                              input logic [15:0] imm, input bit imm_s, input bit wb);
        logic [15:0] a, b, res;
        int ua, ub, sa, sb, t, n;
        exp_t e;
        a  = m_regs[d];
        b  = imm_s ? imm : m_regs[s];
        ua = a;  ub = b;
        sa = $signed(a);  sb = $signed(b);
        n  = ub % 16;
        res = 16'h0;
        case (op)
            0: begin
                t = ua + ub;  res = t[15:0];
                m_flags[4] = (t > 65535);
                t = sa + sb;  m_flags[2] = (t > 32767) || (t < -32768);
            end
            1: begin
                t = ua - ub;  res = t[15:0];
                m_flags[4] = (ua < ub);
                t = sa - sb;  m_flags[2] = (t > 32767) || (t < -32768);
            end
            2: begin
                m_flags[3] = (ua < ub);
                m_flags[1] = (ua == ub);
                m_flags[0] = (sa < sb);
            end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = ~b;
            7:  begin t = ua << n;  res = t[15:0]; end
            8:  begin t = ua >> n;  res = t[15:0]; end
            9:  begin t = sa >>> n; res = t[15:0]; end
            10: res = b;
            default: res = 16'h0;
        endcase
        if (wb && op <= 10 && op != 2) m_regs[d] = res;
        e.op = op;  e.res = res;  e.a = a;  e.b = b;  e.flags = m_flags;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the op is accepted.
    task automatic issue(input int op, input int d, input int s,
                         input logic [15:0] imm, input bit imm_s, input bit wb);
        int stalls = 0;
        int exp_stall;
        bit hit;
        bus.In_Valid    = 1'b1;
        bus.OpCode      = op[3:0];
        bus.RdestRegLoc = d[3:0];
        bus.RsrcRegLoc  = s[3:0];
        bus.Imm         = imm;
        bus.Imm_s       = imm_s;
        bus.Wb_En       = wb;
        hit = (last_wr >= 0) && ((d == last_wr) || (!imm_s && s == last_wr));
        exp_stall = (!FWD && hit) ? 1 : 0;
        #1;
        while (!bus.In_Ready && stalls < 4) begin
            @(negedge Clk);
            stalls++;
            #1;
        end
        check_eq("stall_cycles", stalls, exp_stall);
        model_step(op, d, s, imm, imm_s, wb);
        last_wr = (wb && op <= 10 && op != 2) ? d : -1;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        bus.In_Valid = 1'b0;
        last_wr = -1;
        repeat (n) @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (Rst && bus.Out_Valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.op != 2) check_eq("alu_output", bus.AluOutput, mon_e.res);
                check_eq("rdest_out", bus.RdestOut, mon_e.a);
                check_eq("alu_src_in", bus.AluSrcIn, mon_e.b);
                check_eq("flags", bus.Flags, mon_e.flags);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
        m_flags         = 5'h0;
        bus.In_Valid    = 1'b0;
        bus.OpCode      = 4'h0;
        bus.RdestRegLoc = 4'h0;
        bus.RsrcRegLoc  = 4'h0;
        bus.Imm         = 16'h0;
        bus.Imm_s       = 1'b0;
        bus.Wb_En       = 1'b0;

        #2;
        check_eq("rst_out_valid", bus.Out_Valid, 0);
        check_eq("rst_alu_output", bus.AluOutput, 0);
        check_eq("rst_rdest_out", bus.RdestOut, 0);
        check_eq("rst_alu_src_in", bus.AluSrcIn, 0);
        check_eq("rst_flags", bus.Flags, 0);
        check_eq("rst_in_ready", bus.In_Ready, 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_eq("ready_after_reset", bus.In_Ready, 1);
        @(negedge Clk);

        // Dependent back-to-back pair on R0
        issue(OP_MOV, 0, 0, 16'h0001, 1, 1);
        issue(OP_ADD, 0, 0, 16'h0001, 1, 1);
        idle(3);
        check_eq("r0_after_pair", bus.AluOutput, 16'h0002);

        // Carry and signed overflow
        issue(OP_MOV, 1, 0, 16'hFFFF, 1, 1);
        issue(OP_ADD, 1, 0, 16'h0001, 1, 1);
        issue(OP_MOV, 2, 0, 16'h8000, 1, 1);
        issue(OP_SUB, 2, 0, 16'h0001, 1, 1);
        idle(3);
        check_eq("sub_overflow_f", bus.Flags[FLAG_F], 1);

        // Compare against register and immediate
        issue(OP_MOV, 3, 0, 16'h0005, 1, 1);
        issue(OP_MOV, 4, 0, 16'hFFFE, 1, 1);
        issue(OP_CMP, 3, 4, 16'h0000, 0, 1);
        issue(OP_CMP, 3, 0, 16'h0005, 1, 1);
        issue(OP_MOV, 7, 3, 16'h0000, 0, 0);

        // Shifts on a fixed R5
        issue(OP_MOV, 5, 0, 16'h8001, 1, 1);
        issue(OP_LSH, 5, 0, 16'h0001, 1, 0);
        issue(OP_RSH, 5, 0, 16'h0001, 1, 0);
        issue(OP_ARSH, 5, 0, 16'h0001, 1, 0);
        idle(3);
        check_eq("arsh_result", bus.AluOutput, 16'hC000);

        // Writeback disabled and undefined opcodes
        issue(OP_ADD, 6, 0, 16'h0007, 1, 0);
        issue(12, 6, 0, 16'h0055, 1, 1);
        issue(13, 6, 0, 16'h0000, 1, 0);
        idle(3);

        // Reset while an op sits in EX
        issue(OP_MOV, 8, 0, 16'h0001, 1, 1);
        idle(3);
        issue(OP_ADD, 8, 0, 16'h7FFF, 1, 1);
        bus.In_Valid = 1'b0;
        Rst = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
        m_flags = 5'h0;
        exp_q.delete();
        last_wr = -1;
        #1;
        check_eq("midrst_flags", bus.Flags, 0);
        check_eq("midrst_alu_output", bus.AluOutput, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check_eq("midrst_out_valid", bus.Out_Valid, 0);
        end
        Rst = 1'b1;
        @(negedge Clk);
        check_eq("post_rst_out_valid", bus.Out_Valid, 0);
        issue(13, 8, 0, 16'h0000, 1, 0);
        idle(3);

        // Random traffic over a few registers to provoke hazards
        for (int k = 0; k < 300; k++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                  16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
        end
        idle(5);
        check_eq("pending_results", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_alu_pipe.md
Name: regfile_alu_pipe

Overview:
Parametrised, two-stage pipelined register file plus ALU; successor to the single-cycle regfile/ALU datapath. Accepts one operation per cycle on a valid/ready issue port. Reads operands, executes in a registered EX stage, then writes back to the register file and the flag register. Sits between the future decoder/controller and memory/branch logic.

Parameters:
DATA_W, 16, datapath and register width (>=4)
NUM_REGS, 16, number of registers (power of two, >=2); REG_AW = $clog2(NUM_REGS) is a derived localparam
SH_W, derived localparam $clog2(DATA_W), shift-amount width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
In_Valid  in  1  issue request
In_Ready  out  1  issue accepted when In_Valid && In_Ready at a rising edge
OpCode  in  4  operation
RdestRegLoc  in  REG_AW  destination and first-operand register
RsrcRegLoc  in  REG_AW  source register
Imm  in  DATA_W  immediate operand
Imm_s  in  1  1 = use Imm as source operand, 0 = use Rsrc
Wb_En  in  1  write result to Rdest (ignored for CMP and undefined opcodes)
Out_Valid  out  1  one-cycle pulse: result fields valid
AluOutput  out  DATA_W  registered result
RdestOut  out  DATA_W  registered first operand of the completed op
AluSrcIn  out  DATA_W  registered source operand (post-mux) of the completed op
Flags  out  5  {C,L,F,Z,N} flag register

Behaviour:
- Reset (Rst=0, asynchronous): all registers, Flags, AluOutput, RdestOut, AluSrcIn = 0; Out_Valid = 0; EX stage invalid; any in-flight op is discarded with no writeback.
- Opcodes: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, NOT 6 (~Src), LSH 7, RSH 8 (logical), ARSH 9, MOV 10 (result = Src). Codes 11-15: result 0, no write, flags unchanged.
- Shift operations shift Rdest by Src[SH_W-1:0].
- Issue edge k: operands are sampled into the EX stage (Rdest value, muxed Src, opcode, dest, write flag).
- Edge k+1: the ALU result is written to the register file (if Wb_En and the op writes). At the same edge, Flags update and Out_Valid/AluOutput/RdestOut/AluSrcIn are registered. Out_Valid is high for the cycle after edge k+1.
- Latency is 2 edges. Throughput is 1 op per cycle.
- Flags:
  - ADD/SUB update C (carry out; for SUB, borrow) and F (signed overflow).
  - CMP computes Rdest vs Src and updates L (unsigned Rdest<Src), Z (equal), N (signed Rdest<Src).
  - All other operations leave Flags unchanged.
- Arithmetic is modulo 2^DATA_W.
- All registers, including R0, are writable.
- RAW hazard: the issuing op reads a register (Rdest, or Rsrc when Imm_s=0) that the valid EX-stage op will write.
- The register file has no bypass other than the hazard handling in the optional feature.
- In_Ready = 1 whenever not in reset and no stall is required.
- When In_Valid=0, the EX stage becomes invalid at the next edge and Out_Valid is 0 in the following cycle.

Optional Feature:
REGFILE_ALU_FWD_EN
- Defined: the EX-stage ALU result is forwarded combinationally to the operand read on a RAW hazard. In_Ready never stalls, and back-to-back dependent ops run at 1 per cycle.
- Undefined: on a RAW hazard, In_Ready = 0 for exactly one cycle (one bubble is inserted, with Out_Valid low in the corresponding cycle). The op is then accepted with the written-back value.

Decomposition:
- Package regfile_alu_pkg holds the opcode constants and flag bit indices (C=4, L=3, F=2, Z=1, N=0).
- Sub-module alu_core: a purely combinational ALU parametrised by DATA_W, producing the result plus C/L/F/Z/N. Pipeline registers, register file and hazard logic stay in regfile_alu_pipe.

Test Plan:
- Reset, then issue MOV R0,Imm=1 (Imm_s=1, Wb_En=1) and ADD R0,Imm=1 back-to-back -> AluOutput 1 then 2; R0=2; with FWD_EN no stall, without it one In_Ready=0 cycle.
- Set R1=0xFFFF, then ADD R1,Imm=1 -> AluOutput 0x0000, C=1, F=0; then SUB with R2=0x8000 and Imm=1 -> 0x7FFF, F=1.
- Set R3=5, R4=0xFFFE, then CMP R3,R4 -> L=1, N=0, Z=0, no register write; CMP R3,Imm=5 -> Z=1.
- Set R5=0x8001, then LSH by 1 -> 0x0002; RSH by 1 -> 0x4000; ARSH by 1 -> 0xC000. Flags are unchanged throughout.
- Assert Rst low while an op is in EX -> Out_Valid stays 0, the destination register is unchanged (0), Flags = 0.
- Issue with Wb_En=0 (ADD R6,Imm=7) -> AluOutput 7 with Out_Valid, R6 stays 0; opcode 12 -> AluOutput 0, no write.
